// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

    localparam int              PC_WIDTH   = 16;
    localparam int              INST_WIDTH = 16;
    localparam logic [15:0]     RESET_PC   = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter flop with next-PC selection: reset value, branch target,
// increment or hold, in that priority order.
module pc_register
    import fetch_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = RESET_PC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_rst,
    input  logic             pc_ld,
    input  logic             pc_inc,
    input  logic             pc_addr_sel,
    input  logic [WIDTH-1:0] imd_addr,
    input  logic [WIDTH-1:0] reg_target,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] next_pc;

    // The increment wraps naturally at 2^WIDTH; there is no overflow flag.
    always_comb begin
        next_pc = pc;
        if (pc_rst)
            next_pc = RESET_VALUE;
        else if (pc_ld)
            next_pc = pc_addr_sel ? reg_target : imd_addr;
        else if (pc_inc)
            next_pc = pc + WIDTH'(1);
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_VALUE;
        else
            pc <= next_pc;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction memory requests, instruction
// register with valid/ack handshake, and redirect handling with drain.
module instruction_fetch #(
    parameter int                  PC_WIDTH   = fetch_pkg::PC_WIDTH,
    parameter int                  INST_WIDTH = fetch_pkg::INST_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  fetch_en,
    input  logic                  Pc_Rst,
    input  logic                  Pc_Ld,
    input  logic                  pc_addr_sel,
    input  logic [PC_WIDTH-1:0]   imd_addr,
    input  logic [PC_WIDTH-1:0]   reg_target,
    input  logic                  inst_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic [PC_WIDTH-1:0]   pc_out
);

    import fetch_pkg::fetch_state_t;
    import fetch_pkg::IDLE;
    import fetch_pkg::WAIT;
    import fetch_pkg::HOLD;
    import fetch_pkg::DRAIN;

    fetch_state_t          state;
    logic                  redirect;
    logic                  pc_inc;
    logic [PC_WIDTH-1:0]   pc;

    assign redirect = Pc_Rst | Pc_Ld;
    assign pc_inc   = (state == HOLD) && inst_ack && !redirect;
    assign pc_out   = pc;

    pc_register #(
        .WIDTH       (PC_WIDTH),
        .RESET_VALUE (RESET_PC)
    ) u_pc_register (
        .clk         (clk),
        .rst_n       (Rst),
        .pc_rst      (Pc_Rst),
        .pc_ld       (Pc_Ld),
        .pc_inc      (pc_inc),
        .pc_addr_sel (pc_addr_sel),
        .imd_addr    (imd_addr),
        .reg_target  (reg_target),
        .pc          (pc)
    );

    always_ff @(posedge clk or negedge Rst) begin
        // NOTE: every register in this block gets a reset value; a reset
        // mid-transaction must leave no stale request or instruction behind.
        if (!Rst) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!redirect && fetch_en) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        imem_req <= 1'b0;
                        if (redirect) begin
                            state <= IDLE;
                        end else begin
                            inst       <= imem_rdata;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        // Request stays on the bus; its response is discarded.
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect || inst_ack) begin
                        inst_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-programmable memory responder.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        Pc_Rst = 1'b0;
    logic        Pc_Ld = 1'b0;
    logic        pc_addr_sel = 1'b0;
    logic [15:0] imd_addr = 16'h0;
    logic [15:0] reg_target = 16'h0;
    logic        inst_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_valid = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc_out;

    logic        mem_on = 1'b1;
    logic        force_valid = 1'b0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    int          total = 0;
    int          bad = 0;

    instruction_fetch dut (
        .clk         (clk),
        .Rst         (Rst),
        .fetch_en    (fetch_en),
        .Pc_Rst      (Pc_Rst),
        .Pc_Ld       (Pc_Ld),
        .pc_addr_sel (pc_addr_sel),
        .imd_addr    (imd_addr),
        .reg_target  (reg_target),
        .inst_ack    (inst_ack),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    // Memory answers mem_lat cycles after the request appears; data is addr ^ A5A5.
    always @(negedge clk) begin
        if (mem_on) begin
            if (imem_req) begin
                imem_valid = (wait_cnt >= mem_lat);
                imem_rdata = imem_addr ^ 16'hA5A5;
                wait_cnt   = wait_cnt + 1;
            end else begin
                imem_valid = 1'b0;
                wait_cnt   = 0;
            end
        end else begin
            imem_valid = force_valid;
            imem_rdata = 16'hDEAD;
            wait_cnt   = 0;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 Rst = 1'b0;
        #1;
        check("rst_req",   16'(imem_req), 16'h0);
        check("rst_addr",  imem_addr, 16'h0);
        check("rst_inst",  inst, 16'h0);
        check("rst_valid", 16'(inst_valid), 16'h0);
        check("rst_pc",    pc_out, 16'h0);

        // Sequential fetch, zero-wait memory, ack held high
        fetch_en = 1'b1;
        inst_ack = 1'b1;
        mem_lat  = 0;
        @(negedge clk);
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq_req",  16'(imem_req), 16'h1);
            check("seq_addr", imem_addr, 16'(i));
            step();
            check("seq_valid", 16'(inst_valid), 16'h1);
            check("seq_inst",  inst, 16'(i) ^ 16'hA5A5);
            check("seq_pc",    pc_out, 16'(i));
            step();
            check("seq_idle_valid", 16'(inst_valid), 16'h0);
            check("seq_idle_req",   16'(imem_req), 16'h0);
        end

        // Ack stall in HOLD
        inst_ack = 1'b0;
        step();
        check("stall_addr", imem_addr, 16'h0004);
        step();
        check("stall_valid0", 16'(inst_valid), 16'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_inst",  inst, 16'hA5A1);
            check("stall_pc",    pc_out, 16'h0004);
            check("stall_req",   16'(imem_req), 16'h0);
            check("stall_valid", 16'(inst_valid), 16'h1);
        end
        inst_ack = 1'b1;
        step();
        check("ack_valid", 16'(inst_valid), 16'h0);
        check("ack_req",   16'(imem_req), 16'h0);
        inst_ack = 1'b0;
        step();
        check("after_ack_req",  16'(imem_req), 16'h1);
        check("after_ack_addr", imem_addr, 16'h0005);
        step();
        check("fetch5_inst", inst, 16'hA5A0);
        inst_ack = 1'b1;
        step();
        inst_ack = 1'b0;
        check("fetch5_pc", pc_out, 16'h0006);

        // Redirect while WAIT with latency 3 -> DRAIN
        mem_lat = 3;
        step();
        check("drain_issue_addr", imem_addr, 16'h0006);
        Pc_Ld = 1'b1;
        pc_addr_sel = 1'b0;
        imd_addr = 16'h0040;
        step();
        Pc_Ld = 1'b0;
        check("drain_req_held",  16'(imem_req), 16'h1);
        check("drain_addr_held", imem_addr, 16'h0006);
        check("drain_pc",        pc_out, 16'h0040);
        for (int k = 0; k < 8; k++) begin
            step();
            check("drain_no_valid", 16'(inst_valid), 16'h0);
            if (!imem_req) break;
        end
        check("drain_done", 16'(imem_req), 16'h0);
        step();
        check("redir_req",  16'(imem_req), 16'h1);
        check("redir_addr", imem_addr, 16'h0040);
        mem_lat = 0;
        step();
        check("redir_inst", inst, 16'hA5E5);
        check("redir_pc",   pc_out, 16'h0040);

        // Pc_Rst beats Pc_Ld and ack in HOLD
        fetch_en = 1'b0;
        Pc_Rst = 1'b1;
        Pc_Ld = 1'b1;
        pc_addr_sel = 1'b1;
        reg_target = 16'h1234;
        inst_ack = 1'b1;
        step();
        Pc_Rst = 1'b0;
        Pc_Ld = 1'b0;
        inst_ack = 1'b0;
        check("prio_pc",    pc_out, 16'h0000);
        check("prio_valid", 16'(inst_valid), 16'h0);
        step();
        check("prio_idle_req", 16'(imem_req), 16'h0);

        // Wrap-around from FFFF
        Pc_Ld = 1'b1;
        pc_addr_sel = 1'b1;
        reg_target = 16'hFFFF;
        step();
        Pc_Ld = 1'b0;
        check("wrap_load_pc",  pc_out, 16'hFFFF);
        check("wrap_load_req", 16'(imem_req), 16'h0);
        fetch_en = 1'b1;
        inst_ack = 1'b1;
        step();
        check("wrap_addr", imem_addr, 16'hFFFF);
        step();
        check("wrap_inst", inst, 16'h5A5A);
        step();
        check("wrap_pc", pc_out, 16'h0000);
        step();
        check("wrap_next_addr", imem_addr, 16'h0000);
        check("wrap_next_req",  16'(imem_req), 16'h1);

        // Redirect coinciding with imem_valid in WAIT drops the data
        inst_ack = 1'b0;
        fetch_en = 1'b0;
        Pc_Ld = 1'b1;
        pc_addr_sel = 1'b0;
        imd_addr = 16'h0100;
        step();
        Pc_Ld = 1'b0;
        check("wv_req",   16'(imem_req), 16'h0);
        check("wv_valid", 16'(inst_valid), 16'h0);
        check("wv_pc",    pc_out, 16'h0100);
        check("wv_inst",  inst, 16'h5A5A);

        // Async reset mid-WAIT, then a late response
        mem_lat = 10;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        check("ar_wait_req", 16'(imem_req), 16'h1);
        #2 Rst = 1'b0;
        #1;
        check("ar_req",   16'(imem_req), 16'h0);
        check("ar_addr",  imem_addr, 16'h0);
        check("ar_inst",  inst, 16'h0);
        check("ar_pc",    pc_out, 16'h0);
        mem_on = 1'b0;
        force_valid = 1'b1;
        @(negedge clk);
        Rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("ar_late_valid", 16'(inst_valid), 16'h0);
            check("ar_late_req",   16'(imem_req), 16'h0);
        end
        force_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
